uart_tx_feeder: RTL and testbench

Byte buffer that sits directly upstream of the UART transmitter inside the `tt_um_` top level. A host toggles a strobe pin while presenting a byte on the input pins. The block synchronizes and edge-detects that strobe, then pushes the byte into a small FIFO. The FIFO drains to the transmitter over a valid/ready handshake, so the host can burst several bytes without waiting on the serial line.

---
 rtl/uart_tx_feeder.sv | 89 ++++++++
 tb/tb_uart_tx_feeder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: strobe-driven byte FIFO feeding the UART transmitter.
//
// Ports:
//   clk          - single clock, all state changes on its rising edge
//   rst_n        - synchronous active-low reset
//   wr_strobe    - asynchronous host strobe; each rising edge pushes one byte
//   wr_data      - host byte, held stable around the strobe (not synchronized)
//   tx_data      - head-of-FIFO byte (show-ahead), valid while tx_valid
//   tx_valid     - FIFO non-empty
//   tx_ready     - transmitter takes tx_data this cycle
//   full / empty - level == DEPTH / level == 0
//   level        - number of entries held
//   overflow     - sticky, set when a push is dropped because the FIFO is full
//   clr_overflow - synchronous clear of overflow (a same-cycle drop wins)
module uart_tx_feeder #(
    parameter int DEPTH       = 8,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_strobe,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [DATA_W-1:0]          tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    input  logic                       clr_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic                   overflow_q, overflow_d;
    logic [DATA_W-1:0]      mem_q [DEPTH];
    logic                   push_req, pop, push_ok, drop;

    assign empty    = level_q == '0;
    assign full     = level_q == LW'(DEPTH);
    assign tx_valid = !empty;
    assign tx_data  = mem_q[rd_ptr_q];
    assign level    = level_q;
    assign overflow = overflow_q;

    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign push_req = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign pop      = tx_valid & tx_ready;
    assign push_ok  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], wr_strobe};
        prev_d     = sync_q[SYNC_STAGES-1];
        wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d    = (push_ok && !pop) ? level_q + LW'(1) :
                     (pop && !push_ok) ? level_q - LW'(1) : level_q;
        overflow_d = drop ? 1'b1 : clr_overflow ? 1'b0 : overflow_q;
    end

    // Sync chain and prev reset high so a strobe held across reset is not a push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q     <= '1;
            prev_q     <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push_ok) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed, table-driven check of the strobe-fed TX FIFO.
module tb_uart_tx_feeder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_strobe = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       full, empty, overflow;
    logic [3:0] level;
    logic       clr_overflow = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    uart_tx_feeder #(.DEPTH(8), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .wr_strobe(wr_strobe), .wr_data(wr_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .full(full), .empty(empty), .level(level), .overflow(overflow),
        .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       strobe;
        logic [7:0] data;
        logic       ready;
        int         lvl;
        logic       vld;
        logic [7:0] dat;
        logic       ovf;
    } vec_t;

    vec_t v[$];

    function automatic void add(logic r, logic s, logic [7:0] d, logic rd,
                                int l, logic vl, logic [7:0] dt, logic o);
        vec_t e;
        e.rst_n = r; e.strobe = s; e.data = d; e.ready = rd;
        e.lvl = l; e.vld = vl; e.dat = dt; e.ovf = o;
        v.push_back(e);
    endfunction

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs are set after the previous edge; outputs are sampled 1ns after this edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(string tag, int lvl, logic o);
        chk({tag, " level"}, int'(level), lvl);
        chk({tag, " valid"}, int'(tx_valid), int'(lvl != 0));
        chk({tag, " empty"}, int'(empty), int'(lvl == 0));
        chk({tag, " full"}, int'(full), int'(lvl == 8));
        chk({tag, " overflow"}, int'(overflow), int'(o));
    endtask

    // Strobe high 3 cycles (write lands on the 3rd edge), then low 3 cycles.
    task automatic push(logic [7:0] d, logic rdy_w, logic clr_w);
        wr_data = d;
        for (int i = 0; i < 6; i++) begin
            wr_strobe    = i < 3;
            tx_ready     = (i == 2) && rdy_w;
            clr_overflow = (i == 2) && clr_w;
            step();
        end
        tx_ready = 1'b0;
        clr_overflow = 1'b0;
    endtask

    task automatic drain_one(string tag, logic [7:0] exp);
        chk({tag, " valid"}, int'(tx_valid), 1);
        chk({tag, " data"}, int'(tx_data), int'(exp));
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
    endtask

    initial begin
        // Reset, first push with E0/E1/E2 latency, then strobe held through reset.
        add(0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
        add(1, 0, 8'h00, 0, 0, 0, 8'h00, 0);
        add(1, 1, 8'h41, 0, 0, 0, 8'h00, 0);
        add(1, 1, 8'h41, 0, 0, 0, 8'h00, 0);
        add(1, 1, 8'h41, 0, 1, 1, 8'h41, 0);
        add(1, 0, 8'h41, 0, 1, 1, 8'h41, 0);
        add(1, 0, 8'h41, 0, 1, 1, 8'h41, 0);
        add(1, 0, 8'h41, 0, 1, 1, 8'h41, 0);
        add(0, 1, 8'h00, 1, 0, 0, 8'h00, 0);
        add(1, 1, 8'h00, 0, 0, 0, 8'h00, 0);
        add(1, 1, 8'h00, 0, 0, 0, 8'h00, 0);
        add(1, 1, 8'h00, 0, 0, 0, 8'h00, 0);
        add(1, 0, 8'h55, 0, 0, 0, 8'h00, 0);
        add(1, 0, 8'h55, 0, 0, 0, 8'h00, 0);
        add(1, 0, 8'h55, 0, 0, 0, 8'h00, 0);
        add(1, 1, 8'h55, 0, 0, 0, 8'h00, 0);
        add(1, 1, 8'h55, 0, 0, 0, 8'h00, 0);
        add(1, 1, 8'h55, 0, 1, 1, 8'h55, 0);
        add(1, 1, 8'h55, 0, 1, 1, 8'h55, 0);
        add(1, 1, 8'h55, 0, 1, 1, 8'h55, 0);
        add(1, 0, 8'h55, 1, 0, 0, 8'h00, 0);
        add(1, 0, 8'h55, 0, 0, 0, 8'h00, 0);
        add(1, 0, 8'h55, 0, 0, 0, 8'h00, 0);
        foreach (v[i]) begin
            rst_n = v[i].rst_n; wr_strobe = v[i].strobe;
            wr_data = v[i].data; tx_ready = v[i].ready;
            step();
            chk($sformatf("vec%0d level", i), int'(level), v[i].lvl);
            chk($sformatf("vec%0d valid", i), int'(tx_valid), int'(v[i].vld));
            chk($sformatf("vec%0d empty", i), int'(empty), int'(v[i].lvl == 0));
            chk($sformatf("vec%0d overflow", i), int'(overflow), int'(v[i].ovf));
            if (v[i].vld) chk($sformatf("vec%0d data", i), int'(tx_data), int'(v[i].dat));
        end
        tx_ready = 1'b0;

        // Fill, overflow drop, in-order drain.
        for (int i = 0; i < 8; i++) push(8'(i), 0, 0);
        chk_state("filled", 8, 0);
        push(8'h99, 0, 0);
        chk_state("dropped", 8, 1);
        for (int i = 0; i < 8; i++) drain_one($sformatf("drain%0d", i), 8'(i));
        chk_state("drained", 0, 1);
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        chk_state("cleared", 0, 0);

        // Push and pop together at full: accepted, no overflow.
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), 0, 0);
        push(8'hAA, 1, 0);
        chk_state("push_pop_full", 8, 0);
        for (int i = 1; i < 8; i++) drain_one($sformatf("pp%0d", i), 8'h10 + 8'(i));
        drain_one("pp_aa", 8'hAA);
        chk_state("pp_empty", 0, 0);

        // Pointer wrap: 20 bytes through, two in flight at a time.
        for (int i = 0; i < 20; i += 2) begin
            push(8'h20 + 8'(i), 0, 0);
            push(8'h21 + 8'(i), 0, 0);
            chk($sformatf("wrap%0d level", i), int'(level), 2);
            drain_one($sformatf("wrap%0d", i), 8'h20 + 8'(i));
            drain_one($sformatf("wrap%0d", i + 1), 8'h21 + 8'(i));
        end
        chk_state("wrap_empty", 0, 0);

        // Clear colliding with a drop: set wins.
        for (int i = 0; i < 8; i++) push(8'h60 + 8'(i), 0, 0);
        push(8'h77, 0, 1);
        chk_state("clr_vs_drop", 8, 1);
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        chk_state("clr_after", 8, 0);

        // Reset mid-drain with three bytes queued and ready high.
        for (int i = 0; i < 5; i++) drain_one($sformatf("mid%0d", i), 8'h60 + 8'(i));
        chk_state("mid_level3", 3, 0);
        rst_n = 1'b0;
        tx_ready = 1'b1;
        step();
        rst_n = 1'b1;
        tx_ready = 1'b0;
        chk_state("mid_reset", 0, 0);
        step();
        chk_state("post_reset", 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
